// File: rtl/coin_return_dispenser_if.sv
// Hopper handshake: the dispenser offers one coin at a time and the hopper accepts it.
interface coin_return_dispenser_if;
    logic       o_coin_valid;
    logic [2:0] o_coin;
    logic       i_coin_ready;

    modport master (output o_coin_valid, output o_coin, input  i_coin_ready);
    modport slave  (input  o_coin_valid, input  o_coin, output i_coin_ready);
endinterface

// File: rtl/coin_return_dispenser.sv
// Change return: splits an amount into coins (largest first) drawn from
// per-denomination stock, one coin per hopper handshake.
module coin_return_dispenser #(
    parameter int AMT_W      = 16,
    parameter int CNT_W      = 8,
    parameter int INIT_STOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [AMT_W-1:0]          i_amount,
    input  logic [2:0]                i_refill,
    coin_return_dispenser_if.master   hop,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [AMT_W-1:0]          o_shortfall,
    output logic [CNT_W-1:0]          o_stock_100,
    output logic [CNT_W-1:0]          o_stock_500,
    output logic [CNT_W-1:0]          o_stock_1000
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] OFFER = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] STOCK_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STOCK_INIT = CNT_W'(INIT_STOCK);

    logic [1:0]       state;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       coin_sel;
    logic [2:0]       pick;
    logic [AMT_W-1:0] coin_val;
    logic             handshake;
    logic [2:0]       disp;
    logic [2:0]       refill;
    logic             refill_ok;
    logic [CNT_W-1:0] stock_100, stock_500, stock_1000;

    // Saturating +1 / -1; a simultaneous add and remove cancel out.
    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] cur,
                                              input logic add, input logic sub);
        if (add && !sub)
            return (cur == STOCK_MAX) ? cur : cur + 1'b1;
        else if (sub && !add)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    // Largest coin that fits in remaining and is still in stock.
    always_comb begin
        pick = 3'b000;
        if (remaining >= AMT_W'(1000) && stock_1000 != '0)
            pick = 3'b100;
        else if (remaining >= AMT_W'(500) && stock_500 != '0)
            pick = 3'b010;
        else if (remaining >= AMT_W'(100) && stock_100 != '0)
            pick = 3'b001;
    end

    // Value of the coin currently on offer.
    always_comb begin
        coin_val = '0;
        case (coin_sel)
            3'b100:  coin_val = AMT_W'(1000);
            3'b010:  coin_val = AMT_W'(500);
            3'b001:  coin_val = AMT_W'(100);
            default: coin_val = '0;
        endcase
    end

    assign handshake = (state == OFFER) && hop.i_coin_ready;
    assign disp      = handshake ? coin_sel : 3'b000;
    // Multi-hot refill is illegal and dropped entirely.
    assign refill_ok = (i_refill == 3'b001) || (i_refill == 3'b010) || (i_refill == 3'b100);
    assign refill    = refill_ok ? i_refill : 3'b000;

    // Return sequencing: latch amount, pick coin, offer until accepted, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            coin_sel    <= 3'b000;
            o_error     <= 1'b0;
            o_shortfall <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    remaining   <= i_amount;
                    o_error     <= 1'b0;
                    o_shortfall <= '0;
                    state       <= CHECK;
                end
                CHECK: if (pick != 3'b000) begin
                    coin_sel <= pick;
                    state    <= OFFER;
                end else begin
                    // Covers a clean zero finish and any sub-100 residue.
                    o_error     <= (remaining != '0);
                    o_shortfall <= remaining;
                    state       <= DONE;
                end
                OFFER: if (hop.i_coin_ready) begin
                    remaining <= remaining - coin_val;
                    state     <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stock counters track refills and dispensed coins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            stock_100  <= STOCK_INIT;
            stock_500  <= STOCK_INIT;
            stock_1000 <= STOCK_INIT;
        end else begin
            stock_100  <= step(stock_100,  refill[0], disp[0]);
            stock_500  <= step(stock_500,  refill[1], disp[1]);
            stock_1000 <= step(stock_1000, refill[2], disp[2]);
        end
    end

    assign hop.o_coin_valid = (state == OFFER);
    assign hop.o_coin       = (state == OFFER) ? coin_sel : 3'b000;
    assign o_busy           = (state != IDLE);
    assign o_done           = (state == DONE);
    assign o_stock_100      = stock_100;
    assign o_stock_500      = stock_500;
    assign o_stock_1000     = stock_1000;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed bench for coin_return_dispenser.
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [15:0] i_amount;
    logic [2:0]  i_refill;
    logic        o_busy, o_done, o_error;
    logic [15:0] o_shortfall;
    logic [7:0]  o_stock_100, o_stock_500, o_stock_1000;

    coin_return_dispenser_if hop ();

    coin_return_dispenser dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_amount(i_amount),
        .i_refill(i_refill), .hop(hop), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_shortfall(o_shortfall), .o_stock_100(o_stock_100),
        .o_stock_500(o_stock_500), .o_stock_1000(o_stock_1000)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [2:0]  coins[$];
    int          coin_cyc[$];
    int          done_cyc;
    logic        got_err;
    logic [15:0] got_sf;
    int          stall_bad;
    logic [2:0]  held;

    task automatic do_reset();
        reset = 1'b1; i_start = 1'b0; i_amount = '0; i_refill = 3'b000;
        hop.i_coin_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issue one request (cycle 0 = i_start high) and record coins/handshake cycles.
    task automatic run_req(input logic [15:0] amt, input int stall);
        int left;
        logic [7:0] s1000;
        left = stall; s1000 = '0;
        coins.delete(); coin_cyc.delete();
        done_cyc = -1; stall_bad = 0; got_err = 1'bx; got_sf = 'x; held = 3'b000;
        i_start = 1'b1; i_amount = amt;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (hop.o_coin_valid && left > 0) begin
                if (left == stall) begin
                    held = hop.o_coin; s1000 = o_stock_1000;
                end else if (hop.o_coin !== held || o_stock_1000 !== s1000) begin
                    stall_bad++;
                end
                left--;
                hop.i_coin_ready = 1'b0;
            end else begin
                hop.i_coin_ready = 1'b1;
            end
            if (hop.o_coin_valid && hop.i_coin_ready) begin
                coins.push_back(hop.o_coin);
                coin_cyc.push_back(k);
            end
            if (o_done) begin
                done_cyc = k; got_err = o_error; got_sf = o_shortfall;
                break;
            end
        end
        hop.i_coin_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hop.o_coin_valid, hop.o_coin, o_busy, o_done, o_error} !== 7'b0 || o_shortfall !== 16'd0) begin
            errors++; $display("FAIL reset_outputs: got v=%b c=%b b=%b d=%b e=%b sf=%0d, want all 0",
                hop.o_coin_valid, hop.o_coin, o_busy, o_done, o_error, o_shortfall);
        end
        checks++;
        if ({o_stock_100, o_stock_500, o_stock_1000} !== {8'd4, 8'd4, 8'd4}) begin
            errors++; $display("FAIL reset_stock: got %0d/%0d/%0d, want 4/4/4",
                o_stock_100, o_stock_500, o_stock_1000);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_c [3] = '{3'b100, 3'b010, 3'b001};
        int         exp_k [3] = '{2, 4, 6};
        do_reset();
        run_req(16'd1600, 0);
        checks++;
        if (coins.size() != 3) begin
            errors++; $display("FAIL basic_count: got %0d coins, want 3", coins.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (coins[i] !== exp_c[i] || coin_cyc[i] != exp_k[i]) begin
                    errors++; $display("FAIL basic_coin%0d: got %b@%0d, want %b@%0d",
                        i, coins[i], coin_cyc[i], exp_c[i], exp_k[i]);
                end
            end
        end
        checks++;
        if (done_cyc != 8 || got_err !== 1'b0 || got_sf !== 16'd0) begin
            errors++; $display("FAIL basic_done: got cyc=%0d err=%b sf=%0d, want cyc=8 err=0 sf=0",
                done_cyc, got_err, got_sf);
        end
        checks++;
        if ({o_stock_100, o_stock_500, o_stock_1000} !== {8'd3, 8'd3, 8'd3}) begin
            errors++; $display("FAIL basic_stock: got %0d/%0d/%0d, want 3/3/3",
                o_stock_100, o_stock_500, o_stock_1000);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_req(16'd1600, 5);
        checks++;
        if (held !== 3'b100 || stall_bad != 0) begin
            errors++; $display("FAIL stall_hold: got coin=%b bad=%0d, want coin=100 bad=0", held, stall_bad);
        end
        checks++;
        if (coin_cyc.size() != 3 || coin_cyc[0] != 7 || done_cyc != 13) begin
            errors++; $display("FAIL stall_timing: got n=%0d done=%0d, want n=3 first=7 done=13",
                coin_cyc.size(), done_cyc);
        end
        checks++;
        if ({o_stock_100, o_stock_500, o_stock_1000} !== {8'd3, 8'd3, 8'd3}) begin
            errors++; $display("FAIL stall_stock: got %0d/%0d/%0d, want 3/3/3",
                o_stock_100, o_stock_500, o_stock_1000);
        end
    endtask

    task automatic test_shortage();
        do_reset();
        for (int i = 0; i < 4; i++) run_req(16'd500, 0);
        checks++;
        if (o_stock_500 !== 8'd0 || o_stock_100 !== 8'd4 || o_stock_1000 !== 8'd4) begin
            errors++; $display("FAIL short_drain: got %0d/%0d/%0d, want 4/0/4",
                o_stock_100, o_stock_500, o_stock_1000);
        end
        run_req(16'd500, 0);
        checks++;
        if (coins.size() != 4 || coins[0] !== 3'b001 || coins[3] !== 3'b001) begin
            errors++; $display("FAIL short_coins: got %0d coins, want 4 x 001", coins.size());
        end
        checks++;
        if (done_cyc != 10 || got_err !== 1'b1 || got_sf !== 16'd100) begin
            errors++; $display("FAIL short_done: got cyc=%0d err=%b sf=%0d, want cyc=10 err=1 sf=100",
                done_cyc, got_err, got_sf);
        end
        checks++;
        if (o_error !== 1'b1 || o_shortfall !== 16'd100 || o_busy !== 1'b0) begin
            errors++; $display("FAIL short_hold: got err=%b sf=%0d busy=%b, want 1/100/0",
                o_error, o_shortfall, o_busy);
        end
    endtask

    task automatic test_residue();
        do_reset();
        run_req(16'd750, 0);
        checks++;
        if (coins.size() != 3 || coins[0] !== 3'b010 || coins[1] !== 3'b001 || coins[2] !== 3'b001) begin
            errors++; $display("FAIL residue_coins: got %0d coins, want 010,001,001", coins.size());
        end
        checks++;
        if (got_err !== 1'b1 || got_sf !== 16'd50) begin
            errors++; $display("FAIL residue_done: got err=%b sf=%0d, want err=1 sf=50", got_err, got_sf);
        end
    endtask

    task automatic test_refill();
        do_reset();
        i_start = 1'b1; i_amount = 16'd100;
        @(posedge clk); #1; i_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hop.o_coin_valid !== 1'b1 || hop.o_coin !== 3'b001) begin
            errors++; $display("FAIL refill_offer: got v=%b c=%b, want 1/001", hop.o_coin_valid, hop.o_coin);
        end
        i_refill = 3'b001;
        @(posedge clk); #1; i_refill = 3'b000;
        checks++;
        if (o_stock_100 !== 8'd4) begin
            errors++; $display("FAIL refill_cancel: got %0d, want 4", o_stock_100);
        end
        @(posedge clk); @(posedge clk); #1;
        i_refill = 3'b001;
        repeat (251) @(posedge clk);
        #1;
        checks++;
        if (o_stock_100 !== 8'd255) begin
            errors++; $display("FAIL refill_fill: got %0d, want 255", o_stock_100);
        end
        @(posedge clk); #1;
        checks++;
        if (o_stock_100 !== 8'd255) begin
            errors++; $display("FAIL refill_sat: got %0d, want 255", o_stock_100);
        end
        i_refill = 3'b011;
        @(posedge clk); #1; i_refill = 3'b000;
        checks++;
        if (o_stock_100 !== 8'd255 || o_stock_500 !== 8'd4) begin
            errors++; $display("FAIL refill_multi: got %0d/%0d, want 255/4", o_stock_100, o_stock_500);
        end
    endtask

    task automatic test_reset_offer();
        do_reset();
        i_start = 1'b1; i_amount = 16'd1600; hop.i_coin_ready = 1'b0;
        @(posedge clk); #1; i_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; hop.i_coin_ready = 1'b1;
        checks++;
        if (hop.o_coin_valid !== 1'b0 || o_busy !== 1'b0 || hop.o_coin !== 3'b000 ||
            {o_stock_100, o_stock_500, o_stock_1000} !== {8'd4, 8'd4, 8'd4}) begin
            errors++; $display("FAIL rst_offer: got v=%b b=%b stock=%0d/%0d/%0d, want 0/0 4/4/4",
                hop.o_coin_valid, o_busy, o_stock_100, o_stock_500, o_stock_1000);
        end
        run_req(16'd100, 0);
        checks++;
        if (coins.size() != 1 || coin_cyc[0] != 2 || done_cyc != 4 || got_err !== 1'b0) begin
            errors++; $display("FAIL rst_restart: got n=%0d done=%0d err=%b, want n=1@2 done=4 err=0",
                coins.size(), done_cyc, got_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_shortage();
        test_residue();
        test_refill();
        test_reset_offer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
